// File: rtl/dispatch_queue.sv
// Dispatch queue: DEPTH-entry instruction FIFO with an internal register status table.
// Issues the head to a functional unit when it is free of FU-busy and WAW hazards.
module dispatch_queue #(
  parameter int DEPTH     = 4,
  parameter int NUM_FU    = 3,
  parameter int NREGS     = 32,
  parameter int PAYLOAD_W = 64,
  localparam int REG_W    = $clog2(NREGS),
  localparam int FU_W     = $clog2(NUM_FU),
  localparam int TAG_W    = $clog2(NUM_FU + 1),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FU_W-1:0]      in_fu,
  input  logic                 in_rd_en,
  input  logic [REG_W-1:0]     in_rd,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [NUM_FU-1:0]    fu_busy,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [REG_W-1:0]     wb_rd,
  input  logic [TAG_W-1:0]     wb_tag,
  output logic                 issue_valid,
  output logic [FU_W-1:0]      issue_fu,
  output logic [REG_W-1:0]     issue_rd,
  output logic                 issue_rd_en,
  output logic [REG_W-1:0]     issue_rs1,
  output logic [REG_W-1:0]     issue_rs2,
  output logic [TAG_W-1:0]     issue_t1,
  output logic [TAG_W-1:0]     issue_t2,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [CNT_W-1:0]     count,
  output logic                 hazard
);

  localparam int PTR_W = $clog2(DEPTH);

  // FIFO storage (no reset needed: an entry is always written before it becomes valid)
  logic [FU_W-1:0]      fifo_fu      [DEPTH];
  logic                 fifo_rd_en   [DEPTH];
  logic [REG_W-1:0]     fifo_rd      [DEPTH];
  logic [REG_W-1:0]     fifo_rs1     [DEPTH];
  logic [REG_W-1:0]     fifo_rs2     [DEPTH];
  logic [PAYLOAD_W-1:0] fifo_payload [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NREGS-1:0]            rst_busy_q, rst_busy_d;
  logic [NREGS-1:0][TAG_W-1:0] rst_tag_q, rst_tag_d;

  logic                 issue_valid_q, issue_valid_d;
  logic [FU_W-1:0]      issue_fu_q, issue_fu_d;
  logic [REG_W-1:0]     issue_rd_q, issue_rd_d;
  logic                 issue_rd_en_q, issue_rd_en_d;
  logic [REG_W-1:0]     issue_rs1_q, issue_rs1_d;
  logic [REG_W-1:0]     issue_rs2_q, issue_rs2_d;
  logic [TAG_W-1:0]     issue_t1_q, issue_t1_d;
  logic [TAG_W-1:0]     issue_t2_q, issue_t2_d;
  logic [PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;

  logic                 full, head_valid, head_fu_busy, enq, go;
  logic [FU_W-1:0]      head_fu;
  logic                 head_rd_en;
  logic [REG_W-1:0]     head_rd, head_rs1, head_rs2;
  logic [PAYLOAD_W-1:0] head_payload;
  logic [TAG_W-1:0]     head_tag, src1_tag, src2_tag;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_valid = (count_q != '0);
  assign in_ready   = ~full;

  assign head_fu      = fifo_fu[rd_ptr_q];
  assign head_rd_en   = fifo_rd_en[rd_ptr_q];
  assign head_rd      = fifo_rd[rd_ptr_q];
  assign head_rs1     = fifo_rs1[rd_ptr_q];
  assign head_rs2     = fifo_rs2[rd_ptr_q];
  assign head_payload = fifo_payload[rd_ptr_q];
  assign head_tag     = TAG_W'(head_fu) + TAG_W'(1);

  // An out-of-range FU index never reports busy
  always_comb begin
    head_fu_busy = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (head_fu == FU_W'(i)) head_fu_busy = fu_busy[i];
    end
  end

  assign hazard = head_valid &
                  (head_fu_busy | (head_rd_en & (head_rd != '0) & rst_busy_q[head_rd]));
  assign go     = head_valid & ~hazard & ~freeze & ~flush;
  assign enq    = in_valid & ~full & ~flush;

  // Source tags with same-cycle writeback bypass; r0 is always ready
  always_comb begin
    src1_tag = rst_tag_q[head_rs1];
    src2_tag = rst_tag_q[head_rs2];
    if (head_rs1 == '0 || (wb_en && wb_rd == head_rs1 && wb_tag == src1_tag)) src1_tag = '0;
    if (head_rs2 == '0 || (wb_en && wb_rd == head_rs2 && wb_tag == src2_tag)) src2_tag = '0;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(enq) - CNT_W'(go);
    if (go)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Clear is applied first so that a set of the same register wins
  always_comb begin
    rst_busy_d = rst_busy_q;
    rst_tag_d  = rst_tag_q;
    if (wb_en && rst_busy_q[wb_rd] && rst_tag_q[wb_rd] == wb_tag) begin
      rst_busy_d[wb_rd] = 1'b0;
      rst_tag_d[wb_rd]  = '0;
    end
    if (go && head_rd_en && head_rd != '0) begin
      rst_busy_d[head_rd] = 1'b1;
      rst_tag_d[head_rd]  = head_tag;
    end
  end

  always_comb begin
    issue_valid_d   = go;
    issue_fu_d      = issue_fu_q;
    issue_rd_d      = issue_rd_q;
    issue_rd_en_d   = issue_rd_en_q;
    issue_rs1_d     = issue_rs1_q;
    issue_rs2_d     = issue_rs2_q;
    issue_t1_d      = issue_t1_q;
    issue_t2_d      = issue_t2_q;
    issue_payload_d = issue_payload_q;
    if (go) begin
      issue_fu_d      = head_fu;
      issue_rd_d      = head_rd;
      issue_rd_en_d   = head_rd_en;
      issue_rs1_d     = head_rs1;
      issue_rs2_d     = head_rs2;
      issue_t1_d      = src1_tag;
      issue_t2_d      = src2_tag;
      issue_payload_d = head_payload;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      fifo_fu[wr_ptr_q]      <= in_fu;
      fifo_rd_en[wr_ptr_q]   <= in_rd_en;
      fifo_rd[wr_ptr_q]      <= in_rd;
      fifo_rs1[wr_ptr_q]     <= in_rs1;
      fifo_rs2[wr_ptr_q]     <= in_rs2;
      fifo_payload[wr_ptr_q] <= in_payload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      rst_busy_q      <= '0;
      rst_tag_q       <= '0;
      issue_valid_q   <= 1'b0;
      issue_fu_q      <= '0;
      issue_rd_q      <= '0;
      issue_rd_en_q   <= 1'b0;
      issue_rs1_q     <= '0;
      issue_rs2_q     <= '0;
      issue_t1_q      <= '0;
      issue_t2_q      <= '0;
      issue_payload_q <= '0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      rst_busy_q      <= rst_busy_d;
      rst_tag_q       <= rst_tag_d;
      issue_valid_q   <= issue_valid_d;
      issue_fu_q      <= issue_fu_d;
      issue_rd_q      <= issue_rd_d;
      issue_rd_en_q   <= issue_rd_en_d;
      issue_rs1_q     <= issue_rs1_d;
      issue_rs2_q     <= issue_rs2_d;
      issue_t1_q      <= issue_t1_d;
      issue_t2_q      <= issue_t2_d;
      issue_payload_q <= issue_payload_d;
    end
  end

  assign issue_valid   = issue_valid_q;
  assign issue_fu      = issue_fu_q;
  assign issue_rd      = issue_rd_q;
  assign issue_rd_en   = issue_rd_en_q;
  assign issue_rs1     = issue_rs1_q;
  assign issue_rs2     = issue_rs2_q;
  assign issue_t1      = issue_t1_q;
  assign issue_t2      = issue_t2_q;
  assign issue_payload = issue_payload_q;
  assign count         = count_q;

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
Parametrised successor to the scalar dispatch stage. It buffers pre-decoded instructions from fetch in a DEPTH-entry FIFO and owns an internal register status table (RST) of NREGS entries. It checks the head instruction for structural hazards (FU busy) and WAW hazards, and issues one instruction per cycle to one of NUM_FU functional-unit status tables, with producer tags for both sources. Writeback clears RST entries on tag match.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
NUM_FU, 3, number of functional units; FU index i gets tag i+1, and tag 0 means ready
NREGS, 32, architectural registers; register 0 is never busy
PAYLOAD_W, 64, opaque control/immediate payload carried to issue
Derived: REG_W=$clog2(NREGS), FU_W=$clog2(NUM_FU), TAG_W=$clog2(NUM_FU+1), CNT_W=$clog2(DEPTH+1)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; equals ~full
in_fu  in  FU_W  target FU index
in_rd_en  in  1  instruction writes rd
in_rd  in  REG_W  destination register
in_rs1  in  REG_W  source register 1
in_rs2  in  REG_W  source register 2
in_payload  in  PAYLOAD_W  opaque payload
fu_busy  in  NUM_FU  per-FU busy flags from FUSTs
freeze  in  1  hold the head; no issue this cycle
flush  in  1  discard all queued entries
wb_en  in  1  writeback commit
wb_rd  in  REG_W  writeback register
wb_tag  in  TAG_W  tag of the committing FU
issue_valid  out  1  registered issue strobe, one cycle per instruction
issue_fu  out  FU_W  FU index of the issued instruction
issue_rd  out  REG_W  rd of the issued instruction
issue_rd_en  out  1  rd write enable of the issued instruction
issue_rs1  out  REG_W  rs1 of the issued instruction
issue_rs2  out  REG_W  rs2 of the issued instruction
issue_t1  out  TAG_W  producer tag for rs1 (0 = ready)
issue_t2  out  TAG_W  producer tag for rs2 (0 = ready)
issue_payload  out  PAYLOAD_W  payload of the issued instruction
count  out  CNT_W  current occupancy
hazard  out  1  head valid but blocked by FU busy or WAW

Behaviour:
- Reset (async, nRST=0): FIFO empty, count=0, all RST entries not busy with tag 0, every issue_* output 0, in_ready=1, hazard=0.
- Enqueue: when in_valid & in_ready & ~flush, write the instruction at the tail on the clock edge.
  - No fall-through: a new entry becomes the head no earlier than the next cycle.
  - When the queue is full, in_ready=0 even if a dequeue happens in the same cycle.
- Hazard, evaluated combinationally on the head:
  - hazard = head_valid & (fu_busy[head.fu] | (head.rd_en & head.rd!=0 & rst[head.rd].busy)).
- Dequeue/issue: go = head_valid & ~hazard & ~freeze & ~flush.
  - On go, the head pops and the issue_* registers load next edge; issue_valid=1 for exactly one cycle.
  - Otherwise issue_valid=0 next cycle and the other issue_* fields hold their values.
  - Maximum rate is one issue per cycle.
- Source tags: issue_t1/t2 = rst[rs].tag sampled at issue, with writeback bypass.
  - If wb_en & wb_rd==rs & wb_tag==rst[rs].tag in the same cycle, the tag is 0.
  - A register 0 source always gives tag 0.
- RST set: on go with head.rd_en & head.rd!=0, rst[head.rd] becomes busy with tag head.fu+1.
- RST clear: wb_en & rst[wb_rd].busy & rst[wb_rd].tag==wb_tag clears busy and sets tag to 0. A writeback whose tag does not match is ignored.
- Same-cycle set and clear of the same register: set wins.
- Flush:
  - FIFO empties next edge; count=0; issue_valid=0 next cycle.
  - The same-cycle enqueue is dropped.
  - The RST is unchanged, since in-flight ops still write back; writeback during flush is still honoured.
- Freeze: blocks dequeue only; enqueue proceeds while not full.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from count.
- count = count + enq - deq, saturating is never needed.
- Reset mid-operation: all state returns to reset values immediately, and any pending writebacks are lost.

Test Plan:
- Reset, then enqueue ALU op (fu=0, rd=5, rs1=1, rs2=2) -> issue_valid high 2 cycles after in_valid, t1=t2=0, rst[5] busy with tag 1, count 1 then 0.
- Issue rd=5 via fu=1, then an op with rs1=5 -> issue_t1=2. Send wb_en with wb_rd=5, wb_tag=2 in the issue cycle -> issue_t1=0 (bypass).
- WAW: rd=7 busy (tag 1) and head writes rd=7 -> hazard=1, no issue. wb_rd=7, wb_tag=1 -> issue the next cycle with new tag. A wb_tag=3 mismatch is ignored.
- Hold fu_busy[2]=1 and enqueue 5 ops for fu 2 with DEPTH=4 -> in_ready=0 after 4, count=4. Release busy -> ops issue one per cycle in order, pointers wrap, count returns to 0.
- Queue 3 entries, assert flush with in_valid=1 -> count=0 next cycle, dropped enqueue never issues, previously set RST bits remain busy.
- Assert nRST low mid-stream with 2 queued and rst[3] busy -> all outputs 0 and count 0 immediately, rst[3] not busy after release.
